seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Multi-digit display controller for the Morse decoder front panel. Keeps a buffer of decoded 4-bit symbols that scrolls left on each new entry, and supports backspace and clear. Time-multiplexes the buffer onto a shared active-low 7-segment bus with one anode strobe per digit. Sits between the symbol decoder/keyboard path and the board's segment and anode pins.

Parameters:
NUM_DIGITS, 8, number of digit positions; range 2..8.
REFRESH_DIV, 100000, clk cycles each digit is lit before the scan advances; must be >= 2.
BLINK_DIV, 64, full scan rotations per blink phase; used only with SCAN_BLINK_EN.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
push  in  1  single-cycle strobe: enter push_val as newest digit
push_val  in  4  hex symbol 0x0..0xF
bksp  in  1  single-cycle strobe: delete newest digit
clr  in  1  single-cycle strobe: empty buffer
an  out  NUM_DIGITS  anode enables, active-low, one-hot-low while scanning
seg  out  8  segments, active-low; bit7=dp, bits6..0=g..a
count  out  4  number of valid digits, 0..NUM_DIGITS
full  out  1  count == NUM_DIGITS
ovf  out  1  one-cycle pulse when a push discards the oldest digit

Behaviour:
- Reset (async assert, sync-safe release):
  - an all ones, seg 8'hFF, count 0, full 0, ovf 0.
  - All slots invalid, scan index 0, refresh divider 0.
- Buffer:
  - Slot 0 is the rightmost, newest digit. Each slot holds a 4-bit value and a valid bit.
- Command priority per cycle: clr > push > bksp. Lower-priority strobes in the same cycle are dropped, not queued.
- clr: all slots invalid and count=0 on the next edge.
- push, count < NUM_DIGITS:
  - Slot i takes slot i-1; slot 0 takes push_val with valid=1.
  - count+1.
- push, full:
  - Same shift; the value in slot NUM_DIGITS-1 is lost.
  - count unchanged; ovf=1 for exactly one cycle.
- bksp, count > 0:
  - Slot i takes slot i+1; top slot becomes invalid.
  - count-1.
- bksp, count == 0: no-op. No underflow; count stays 0.
- count and full are registered and update on the same edge as the buffer.
- Scan:
  - Refresh divider counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, scan index increments modulo NUM_DIGITS (NUM_DIGITS-1 wraps to 0).
- Output stage:
  - an and seg are registered, one cycle after the scan index or buffer changes.
  - an[k]=0 only for k == scan index.
  - seg = LUT(slot[k]) if slot k is valid, else 8'hFF (leading positions blank).
  - dp is always 1 (off).
- LUT, fixed: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E.
- A command landing mid-scan is visible from the next registered output; there is no tearing within a digit slot.
- rst asserted mid-operation returns every output to its reset values immediately.

Optional Feature:
SCAN_BLINK_EN
- Defined:
  - A blink counter advances once per full scan rotation (scan index wraps to 0).
  - The blink phase toggles every BLINK_DIV rotations; phase starts at 0 on reset.
  - While phase=1 and count>0, slot 0 is driven as 8'hFF, marking the newest entry.
  - Any push, bksp or clr resets the phase to 0 and the blink counter to 0.
- Undefined: no blink logic; BLINK_DIV is ignored and slot 0 is always shown normally.

Decomposition:
- Package seg_pkg:
  - SEG_BLANK = 8'hFF.
  - The 16-entry hex-to-segment constant table.
  - A typedef for a digit slot: 4-bit value plus valid bit.
  - Command priority encoding: CMD_NONE, CMD_CLR, CMD_PUSH, CMD_BKSP.
- Sub-module seg_refresh_tick: parameterised divider producing a one-cycle tick on wrap.
- Buffer, scan index and LUT stay in seg_scan_ctrl.

Test Plan:
- Reset then idle, NUM_DIGITS=4, REFRESH_DIV=4 -> an cycles E,D,B,7 every 4 clks; seg=FF in all slots; count=0.
- Push 1,2,3 -> count=3; seg=B0 while an[0]=0, A4 at an[1], F9 at an[2], FF at an[3].
- Push 0..4 into a 4-digit buffer -> ovf pulses once on the fifth push; full=1; slots 3..0 hold 1,2,3,4.
- bksp with count=2, then bksp three more times -> count 1, then 0; extra bksp leaves count 0 and all seg FF.
- Same-cycle push+bksp -> push applied; same-cycle clr+push -> buffer empty, count=0, ovf=0.
- SCAN_BLINK_EN, BLINK_DIV=2, one digit 'A' -> slot 0 alternates 88/FF every 2 rotations; a push resets phase to 0 (visible).

Source files
------------

// File: rtl/seg_pkg.sv
// ============================================================================
// Module   : seg_pkg
// Purpose  : Shared types, segment table and command encoding for the
//            multiplexed 7-segment scan controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low segment patterns, bit7 = dp (always off), bits6..0 = g..a
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct packed {
    logic       valid;
    logic [3:0] value;
  } slot_t;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_CLR  = 2'd1,
    CMD_PUSH = 2'd2,
    CMD_BKSP = 2'd3
  } cmd_e;

  function automatic cmd_e decode_cmd(input logic i_clr, input logic i_push,
                                      input logic i_bksp);
    if (i_clr)       return CMD_CLR;
    else if (i_push) return CMD_PUSH;
    else if (i_bksp) return CMD_BKSP;
    else             return CMD_NONE;
  endfunction

  function automatic logic [7:0] slot_to_seg(input slot_t s);
    return s.valid ? SEG_LUT[s.value] : SEG_BLANK;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_refresh_tick.sv
// ============================================================================
// Module   : seg_refresh_tick
// Purpose  : Free-running 0..DIV-1 divider; o_tick is high in the last count,
//            so the consumer advances on the same edge the divider wraps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_refresh_tick #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int c_CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [c_CW-1:0] r_cnt;

  assign o_tick = (r_cnt == c_CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_cnt <= '0;
    else if (o_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + c_CW'(1);
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Scrolling digit buffer with push/backspace/clear, multiplexed
//            onto an active-low 7-segment bus. Optional macro SCAN_BLINK_EN
//            blinks the newest digit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [3:0]            push_val,
  input  logic                  bksp,
  input  logic                  clr,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            seg,
  output logic [3:0]            count,
  output logic                  full,
  output logic                  ovf
);

  localparam int                    c_IW       = $clog2(NUM_DIGITS);
  localparam logic [c_IW-1:0]       c_IDX_LAST = c_IW'(NUM_DIGITS - 1);
  localparam logic [3:0]            c_FULL_CNT = 4'(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] c_AN_ONE   = NUM_DIGITS'(1);

  slot_t                 r_slot [NUM_DIGITS];
  logic [3:0]            r_count;
  logic                  r_full;
  logic                  r_ovf;
  logic [c_IW-1:0]       r_idx;
  logic [NUM_DIGITS-1:0] r_an;
  logic [7:0]            r_seg;

  cmd_e                  w_cmd;
  logic                  w_tick;
  logic                  w_wrap;
  logic                  w_blank0;
  logic [NUM_DIGITS-1:0] w_an_nxt;
  logic [7:0]            w_seg_nxt;

  assign w_cmd = decode_cmd(clr, push, bksp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_slot[i] <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      case (w_cmd)
        CMD_CLR: begin
          for (int i = 0; i < NUM_DIGITS; i++) r_slot[i] <= '0;
          r_count <= '0;
          r_full  <= 1'b0;
        end
        CMD_PUSH: begin
          for (int i = 1; i < NUM_DIGITS; i++) r_slot[i] <= r_slot[i-1];
          r_slot[0] <= '{valid: 1'b1, value: push_val};
          if (r_full) begin
            r_ovf <= 1'b1;
          end else begin
            r_count <= r_count + 4'd1;
            r_full  <= (r_count == c_FULL_CNT - 4'd1);
          end
        end
        CMD_BKSP: begin
          if (r_count != 4'd0) begin
            for (int i = 0; i < NUM_DIGITS - 1; i++) r_slot[i] <= r_slot[i+1];
            r_slot[NUM_DIGITS-1] <= '0;
            r_count <= r_count - 4'd1;
            r_full  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  seg_refresh_tick #(.DIV(REFRESH_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick)
  );

  assign w_wrap = w_tick && (r_idx == c_IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_idx <= '0;
    else if (w_wrap) r_idx <= '0;
    else if (w_tick) r_idx <= r_idx + c_IW'(1);
  end

`ifdef SCAN_BLINK_EN
  localparam int c_BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [c_BW-1:0] r_blink_cnt;
  logic            r_phase;

  // Any strobe restarts the blink so a fresh entry is shown lit first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (push || bksp || clr) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_wrap) begin
      if (r_blink_cnt == c_BW'(BLINK_DIV - 1)) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + c_BW'(1);
      end
    end
  end

  assign w_blank0 = r_phase && (r_count != 4'd0);
`else
  // BLINK_DIV has no function without the blink feature
  logic w_unused_blink_div;
  assign w_unused_blink_div = (BLINK_DIV != 0);
  assign w_blank0           = 1'b0;
`endif

  always_comb begin
    w_an_nxt  = ~(c_AN_ONE << r_idx);
    w_seg_nxt = slot_to_seg(r_slot[r_idx]);
    if (w_blank0 && (r_idx == '0)) w_seg_nxt = SEG_BLANK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign an    = r_an;
  assign seg   = r_seg;
  assign count = r_count;
  assign full  = r_full;
  assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Directed self-checking bench for seg_scan_ctrl (4 digits, 4-clk
//            refresh); blink sequence included when SCAN_BLINK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BD = 2;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          push     = 1'b0;
  logic [3:0]    push_val = 4'h0;
  logic          bksp     = 1'b0;
  logic          clr      = 1'b0;
  logic [ND-1:0] an;
  logic [7:0]    seg;
  logic [3:0]    count;
  logic          full;
  logic          ovf;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLINK_DIV   (BD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_val (push_val),
    .bksp     (bksp),
    .clr      (clr),
    .an       (an),
    .seg      (seg),
    .count    (count),
    .full     (full),
    .ovf      (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cmd(input logic p, input logic [3:0] v, input logic b, input logic c);
    push = p; push_val = v; bksp = b; clr = c;
    tick();
    push = 1'b0; bksp = 1'b0; clr = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (an === target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic seg_at(input int k, input logic [7:0] exp, input string tag);
    logic [3:0] t;
    bit ok;
    t = ~(4'b0001 << k);
    tick();
    wait_an(t, ok);
    if (!ok) chk({tag, "_wait"}, {31'd0, ok}, 32'd1);
    else     chk(tag, {24'd0, seg}, {24'd0, exp});
  endtask

  // Value of seg on the first cycle of the next digit-0 visit
  task automatic next_visit0(output logic [7:0] s);
    bit ok1, ok2;
    wait_an(4'h7, ok1);
    wait_an(4'hE, ok2);
    if (!(ok1 && ok2)) chk("visit0_wait", {31'd0, ok1 && ok2}, 32'd1);
    s = seg;
  endtask

  initial begin
    logic [3:0] exp_an;
    logic [7:0] s;
    bit ok;

    repeat (3) tick();
    chk("rst_an",    {28'd0, an},    32'hF);
    chk("rst_seg",   {24'd0, seg},   32'hFF);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_full",  {31'd0, full},  32'd0);
    chk("rst_ovf",   {31'd0, ovf},   32'd0);

    // Idle scan: each anode held for 4 clocks, order E,D,B,7
    rst = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      tick();
      exp_an = ~(4'b0001 << ((n - 1) / 4));
      chk("idle_an",  {28'd0, an},  {28'd0, exp_an});
      chk("idle_seg", {24'd0, seg}, 32'hFF);
    end
    chk("idle_count", {28'd0, count}, 32'd0);

    cmd(1'b1, 4'h1, 1'b0, 1'b0);
    cmd(1'b1, 4'h2, 1'b0, 1'b0);
    cmd(1'b1, 4'h3, 1'b0, 1'b0);
    chk("p3_count", {28'd0, count}, 32'd3);
    chk("p3_full",  {31'd0, full},  32'd0);
    seg_at(0, 8'hB0, "p3_seg0");
    seg_at(1, 8'hA4, "p3_seg1");
    seg_at(2, 8'hF9, "p3_seg2");
    seg_at(3, 8'hFF, "p3_seg3");

    cmd(1'b0, 4'h0, 1'b0, 1'b1);
    for (int v = 0; v < 4; v++) begin
      cmd(1'b1, 4'(v), 1'b0, 1'b0);
      chk("fill_ovf", {31'd0, ovf}, 32'd0);
    end
    chk("fill_full",  {31'd0, full},  32'd1);
    chk("fill_count", {28'd0, count}, 32'd4);
    cmd(1'b1, 4'h4, 1'b0, 1'b0);
    chk("ovf_pulse", {31'd0, ovf},   32'd1);
    chk("ovf_full",  {31'd0, full},  32'd1);
    chk("ovf_count", {28'd0, count}, 32'd4);
    tick();
    chk("ovf_clear", {31'd0, ovf}, 32'd0);
    seg_at(0, 8'h99, "ovf_seg0");
    seg_at(1, 8'hB0, "ovf_seg1");
    seg_at(2, 8'hA4, "ovf_seg2");
    seg_at(3, 8'hF9, "ovf_seg3");

    cmd(1'b0, 4'h0, 1'b0, 1'b1);
    cmd(1'b1, 4'h5, 1'b0, 1'b0);
    cmd(1'b1, 4'h6, 1'b0, 1'b0);
    chk("bk_count2", {28'd0, count}, 32'd2);
    cmd(1'b0, 4'h0, 1'b1, 1'b0);
    chk("bk_count1", {28'd0, count}, 32'd1);
    seg_at(0, 8'h92, "bk_seg0");
    seg_at(1, 8'hFF, "bk_seg1");
    cmd(1'b0, 4'h0, 1'b1, 1'b0);
    chk("bk_count0", {28'd0, count}, 32'd0);
    cmd(1'b0, 4'h0, 1'b1, 1'b0);
    cmd(1'b0, 4'h0, 1'b1, 1'b0);
    chk("bk_under", {28'd0, count}, 32'd0);
    chk("bk_full",  {31'd0, full},  32'd0);
    seg_at(0, 8'hFF, "bk_empty0");
    seg_at(1, 8'hFF, "bk_empty1");

    cmd(1'b1, 4'h7, 1'b1, 1'b0);
    chk("pb_count", {28'd0, count}, 32'd1);
    seg_at(0, 8'hF8, "pb_seg0");
    cmd(1'b1, 4'h1, 1'b0, 1'b0);
    cmd(1'b1, 4'h2, 1'b0, 1'b0);
    cmd(1'b1, 4'h3, 1'b0, 1'b0);
    cmd(1'b1, 4'h9, 1'b0, 1'b1);
    chk("cp_count", {28'd0, count}, 32'd0);
    chk("cp_ovf",   {31'd0, ovf},   32'd0);
    chk("cp_full",  {31'd0, full},  32'd0);
    seg_at(0, 8'hFF, "cp_seg0");

    // Asynchronous reset mid-cycle
    cmd(1'b1, 4'h8, 1'b0, 1'b0);
    seg_at(0, 8'h80, "ar_pre");
    #2 rst = 1'b1;
    #1;
    chk("ar_an",    {28'd0, an},    32'hF);
    chk("ar_seg",   {24'd0, seg},   32'hFF);
    chk("ar_count", {28'd0, count}, 32'd0);
    tick();
    rst = 1'b0;

`ifdef SCAN_BLINK_EN
    wait_an(4'hD, ok);
    wait_an(4'hB, ok);
    cmd(1'b1, 4'hA, 1'b0, 1'b0);
    next_visit0(s); chk("blink_v1", {24'd0, s}, 32'h88);
    next_visit0(s); chk("blink_v2", {24'd0, s}, 32'hFF);
    next_visit0(s); chk("blink_v3", {24'd0, s}, 32'hFF);
    next_visit0(s); chk("blink_v4", {24'd0, s}, 32'h88);
    next_visit0(s); chk("blink_v5", {24'd0, s}, 32'h88);
    next_visit0(s); chk("blink_v6", {24'd0, s}, 32'hFF);
    wait_an(4'hD, ok);
    wait_an(4'hB, ok);
    cmd(1'b1, 4'hB, 1'b0, 1'b0);
    next_visit0(s); chk("blink_rs1", {24'd0, s}, 32'h83);
    next_visit0(s); chk("blink_rs2", {24'd0, s}, 32'hFF);
`else
    ok = 1'b0;
    s  = 8'h00;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
